// File: rtl/dp_sequencer.sv
// Issue/sequencing stage for ARM data-processing instructions: condition check,
// operand fetch and shifter, ALU drive, then Rd and NZCV write-back.
module dp_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    output logic [3:0]            rn_addr,
    output logic [3:0]            rm_addr,
    input  logic [DATA_WIDTH-1:0] rn_data,
    input  logic [DATA_WIDTH-1:0] rm_data,
    output logic                  rd_we,
    output logic [3:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  alu_enable,
    output logic [3:0]            alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_operand1,
    output logic [DATA_WIDTH-1:0] alu_operand2,
    output logic                  alu_carry_in,
    output logic                  alu_flag_update,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_n,
    input  logic                  alu_z,
    input  logic                  alu_c,
    input  logic                  alu_v,
    output logic [3:0]            flags_nzcv,
    output logic                  done,
    output logic                  skipped,
    output logic                  illegal
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    state_t                state, state_next;
    logic [31:0]           instr_q;
    logic [DATA_WIDTH-1:0] op1_q, op2_q, result_q;
    logic                  shc_q, exec_q, illegal_q;
    logic [3:0]            flags_q;

    logic                  flag_n, flag_z, flag_c, flag_v;
    logic [3:0]            opcode;
    logic                  is_arith, writes_rd, legal, cond_pass;
    logic [4:0]            shamt, lsl_tap;
    logic [DATA_WIDTH-1:0] shift_val, imm_ext;
    logic [2*DATA_WIDTH-1:0] rot_dbl;
    logic                  shift_carry;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
    assign opcode    = instr_q[24:21];
    // Arithmetic/compare opcodes: SUB..RSC (0010-0111) and CMP/CMN (101x)
    assign is_arith  = (opcode[3:2] == 2'b01) || (opcode[3:1] == 3'b001) || (opcode[3:1] == 3'b101);
    assign writes_rd = (opcode[3:2] != 2'b10);
    assign legal     = (instr_q[27:26] == 2'b00) && (instr_q[25] || !instr_q[4]);
    assign shamt     = instr_q[11:7];
    assign lsl_tap   = 5'd0 - shamt;

    always_comb begin
        cond_pass = 1'b0;
        case (instr_q[31:28])
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Shifter operand; a zero shift amount encodes the special LSR/ASR #32 and RRX forms
    always_comb begin
        shift_val   = rm_data;
        shift_carry = flag_c;
        imm_ext     = {{(DATA_WIDTH-8){1'b0}}, instr_q[7:0]};
        rot_dbl     = '0;
        if (instr_q[25]) begin
            rot_dbl   = {imm_ext, imm_ext} >> {instr_q[11:8], 1'b0};
            shift_val = rot_dbl[DATA_WIDTH-1:0];
            if (instr_q[11:8] != 4'd0)
                shift_carry = rot_dbl[DATA_WIDTH-1];
        end else begin
            case (instr_q[6:5])
                2'b00: if (shamt != 5'd0) begin
                    shift_val   = rm_data << shamt;
                    shift_carry = rm_data[lsl_tap];
                end
                2'b01: if (shamt == 5'd0) begin
                    shift_val   = '0;
                    shift_carry = rm_data[DATA_WIDTH-1];
                end else begin
                    shift_val   = rm_data >> shamt;
                    shift_carry = rm_data[shamt - 5'd1];
                end
                2'b10: if (shamt == 5'd0) begin
                    shift_val   = {DATA_WIDTH{rm_data[DATA_WIDTH-1]}};
                    shift_carry = rm_data[DATA_WIDTH-1];
                end else begin
                    shift_val   = $signed(rm_data) >>> shamt;
                    shift_carry = rm_data[shamt - 5'd1];
                end
                default: if (shamt == 5'd0) begin
                    shift_val   = {flag_c, rm_data[DATA_WIDTH-1:1]};
                    shift_carry = rm_data[0];
                end else begin
                    rot_dbl     = {rm_data, rm_data} >> shamt;
                    shift_val   = rot_dbl[DATA_WIDTH-1:0];
                    shift_carry = rm_data[shamt - 5'd1];
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        rn_addr     = 4'd0;
        rm_addr     = 4'd0;
        alu_enable  = 1'b0;
        rd_we       = 1'b0;
        done        = 1'b0;
        skipped     = 1'b0;
        illegal     = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = !reset;
                if (instr_valid)
                    state_next = READ;
            end
            READ: begin
                rn_addr    = instr_q[19:16];
                rm_addr    = instr_q[3:0];
                state_next = (legal && cond_pass) ? EXEC : WRITE;
            end
            EXEC: begin
                rn_addr    = instr_q[19:16];
                rm_addr    = instr_q[3:0];
                alu_enable = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                done       = 1'b1;
                skipped    = !exec_q;
                illegal    = illegal_q;
                rd_we      = exec_q && writes_rd;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Flags are committed at the end of EXEC so the WRITE cycle already shows them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q   <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            result_q  <= '0;
            shc_q     <= 1'b0;
            exec_q    <= 1'b0;
            illegal_q <= 1'b0;
            flags_q   <= 4'd0;
        end else begin
            case (state)
                IDLE: if (instr_valid) instr_q <= instr;
                READ: begin
                    op1_q     <= rn_data;
                    op2_q     <= shift_val;
                    shc_q     <= shift_carry;
                    exec_q    <= legal && cond_pass;
                    illegal_q <= !legal;
                end
                EXEC: begin
                    result_q <= alu_result;
                    if (instr_q[20])
                        flags_q <= {alu_n, alu_z, alu_c, is_arith ? alu_v : flag_v};
                end
                default: ;
            endcase
        end
    end

    assign rd_addr         = instr_q[15:12];
    assign rd_data         = result_q;
    assign alu_opcode      = opcode;
    assign alu_operand1    = op1_q;
    assign alu_operand2    = op2_q;
    assign alu_carry_in    = is_arith ? flag_c : shc_q;
    assign alu_flag_update = instr_q[20];
    assign flags_nzcv      = flags_q;

endmodule

// File: doc/dp_sequencer.md
# dp_sequencer

Multi-cycle issue/sequencing stage for ARM data-processing instructions. It accepts one instruction word and evaluates its condition field against its own NZCV register. It then reads Rn/Rm from the register file and builds the shifter operand. It drives the combinational ALU's opcode/operand/carry/flag-update inputs, samples the result and flags, and writes back Rd and NZCV. It sits between fetch/decode and the ALU plus register file, and is the only agent that drives the ALU.

## Interface
- DATA_WIDTH, 32, datapath width; the shifter and immediate-rotate rules below are defined for 32 only.
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; forces IDLE and clears all registers
- instr_valid  input  1  instruction offered
- instr_ready  output  1  high only in IDLE; transfer when valid & ready
- instr  input  32  instruction word
- rn_addr, rm_addr  output  4 each  register-file read addresses (combinational read)
- rn_data, rm_data  input  DATA_WIDTH each  read data
- rd_we  output  1  one-cycle write strobe
- rd_addr  output  4  write address
- rd_data  output  DATA_WIDTH  write data
- alu_enable  output  1  high in EXEC only
- alu_opcode  output  4  instr[24:21]
- alu_operand1, alu_operand2  output  DATA_WIDTH each  Rn value, shifter operand
- alu_carry_in  output  1  see Operation
- alu_flag_update  output  1  S bit (instr[20])
- alu_result  input  DATA_WIDTH  ALU result
- alu_n, alu_z, alu_c, alu_v  input  1 each  ALU flags
- flags_nzcv  output  4  architectural NZCV
- done  output  1  one-cycle pulse at end of every accepted instruction
- skipped  output  1  valid with done; condition failed or illegal
- illegal  output  1  valid with done; unsupported encoding

## Operation
- FSM states are IDLE, READ, EXEC and WRITE. Transitions:
  - IDLE to READ on handshake; latch instr.
  - READ to EXEC when the instruction is legal and the condition passes.
  - READ to WRITE otherwise, with no writes.
  - EXEC to WRITE always.
  - WRITE to IDLE always.
- Field map: cond[31:28], class[27:26] must be 00, I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], op2[11:0].
- Illegal encodings: class != 00, or I=0 with bit4=1 (register-specified shift). Both give illegal=1 and skipped=1.
- Condition codes: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1110 always passes; 1111 never passes.
- Immediate operand (I=1): imm8 rotated right by 2*rot[11:8]. Shifter carry = C if rot==0, else operand bit 31.
- Register operand (I=0): Rm shifted by imm5[11:7] according to type[6:5].
  - LSL: imm5=0 passes Rm with carry C; otherwise carry = Rm[32-imm5].
  - LSR: imm5=0 means shift 32, giving 0 with carry Rm[31]; otherwise carry = Rm[imm5-1].
  - ASR: imm5=0 means shift 32, giving all Rm[31] with carry Rm[31].
  - ROR: imm5=0 means RRX, {C,Rm[31:1]} with carry Rm[0]; otherwise rotate, carry = Rm[imm5-1].
- alu_carry_in is the current C for opcodes SUB, RSB, ADD, ADC, SBC, RSC, CMP and CMN. For logical opcodes it is the shifter carry, which the ALU reflects as its C.
- Rd write: rd_we=1 in WRITE iff the instruction executed and the opcode is not TST, TEQ, CMP or CMN. rd_addr=Rd, rd_data=alu_result captured in EXEC.
- NZCV update happens in WRITE iff the instruction executed and S=1. N, Z and C are taken from the captured ALU flags. V is taken from alu_v only for arithmetic or compare opcodes and is unchanged for logical opcodes.
- Rd=15 is treated as an ordinary register; PC redirect is outside this block.

## Timing
- Handshake at edge 0 enters READ. EXEC follows at edge 1 and WRITE at edge 2; done, rd_we and the NZCV update are all visible during cycle 3. IDLE returns at edge 3.
- Throughput is one instruction per 4 cycles. Skipped and illegal instructions also take 3 cycles: handshake, READ, then WRITE.
- rn_addr and rm_addr are driven from the latched instr in READ and EXEC. Rn/Rm data and the shifter operand are registered at the end of READ.
- ALU outputs are sampled at the end of EXEC. alu_enable is 0 outside EXEC, and ALU inputs must be stable throughout EXEC.
- A flags change from instruction k is visible to the condition check of instruction k+1.
- Reset, asynchronous at any state, forces:
  - instr_ready=0 while reset is asserted, then 1 in IDLE.
  - rd_we, done, skipped, illegal and alu_enable all 0.
  - All address and data outputs 0.
  - flags_nzcv=0000.
  - An in-flight instruction is discarded with no write.

## Test plan
- MOVS r1,#0xFF000000 (0xE3B014FF) -> rd_we with r1=0xFF000000, NZCV=1010, done in cycle 3.
- ADDS r2,r3,r4 (0xE0932004), r3=0x7FFFFFFF, r4=1 -> r2=0x80000000, NZCV=1001.
- CMP r3,r3 (0xE1530003) then MOVNE r1,#1 (0x13A01001) -> CMP: no rd_we, Z=1. MOVNE: done with skipped=1, no rd_we, NZCV unchanged.
- C=1, MOVS r5,r6,RRX (0xE1B05066), r6=2 -> r5=0x80000001, N=1, C=0, V unchanged.
- 0xEA000000 and 0xE1A00011 -> done with skipped=1 and illegal=1 each, no rd_we, no NZCV change.
- Reset asserted during EXEC of ADDS -> no rd_we, NZCV=0000, instr_ready=1 the cycle after reset deasserts.
